gf2_mul_scheduler: RTL

- Sequences one shared word-level GF(2) carry-less multiplier (WW x WW -> 2*WW) across all NW*NW word pairs of two NW*WW-bit operands.
- XOR-accumulates each partial product into a 2*NW*WW-bit result register.
- Sits between the top-level multiplier wrapper and the base multiplier core, so one small core serves a wide product.

---
 rtl/gf2_mul_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gf2_mul_scheduler.sv
// Word-serial GF(2) multiplication scheduler: sequences one shared WW x WW carry-less
// core over all NW*NW word pairs and XOR-accumulates partial products into W.
module gf2_mul_scheduler #(
    parameter int NW = 4,
    parameter int WW = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NW*WW-1:0]     U,
    input  logic [NW*WW-1:0]     V,
    output logic                 mul_req,
    output logic [WW-1:0]        mul_a,
    output logic [WW-1:0]        mul_b,
    input  logic                 mul_ack,
    input  logic [2*WW-1:0]      mul_p,
    output logic [2*NW*WW-1:0]   W,
    output logic                 busy,
    output logic                 done,
    output logic                 proto_err
);
    localparam int OW = NW * WW;
    localparam int RW = 2 * NW * WW;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [OW-1:0]   a_q, a_d;
    logic [OW-1:0]   b_q, b_d;
    logic [RW-1:0]   w_q, w_d;
    logic [WW-1:0]   mul_a_q, mul_a_d;
    logic [WW-1:0]   mul_b_q, mul_b_d;
    logic            mul_req_q, mul_req_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            proto_err_q, proto_err_d;

    function automatic logic [WW-1:0] get_word(input logic [OW-1:0] op,
                                               input logic [IW-1:0] idx);
        return WW'(op >> (32'(idx) * 32'(WW)));
    endfunction

    // A partial product for pair (i,j) lands at bit offset (i+j)*WW of the result
    function automatic logic [RW-1:0] place_product(input logic [2*WW-1:0] p,
                                                    input logic [IW-1:0]   i,
                                                    input logic [IW-1:0]   j);
        return RW'(p) << ((32'(i) + 32'(j)) * 32'(WW));
    endfunction

    // Next-state, accumulation and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        a_d         = a_q;
        b_d         = b_q;
        w_d         = w_q;
        proto_err_d = proto_err_q | (mul_ack & ~mul_req_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = U;
                    b_d     = V;
                    w_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = state_q;
                end
            end
            S_ISSUE: begin
                if (mul_ack) begin
                    w_d     = w_q ^ place_product(mul_p, i_q, j_q);
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ACCUM: begin
                if ((i_q == LAST_IDX) && (j_q == LAST_IDX)) begin
                    state_d = S_DONE;
                end else if (j_q == LAST_IDX) begin
                    j_d     = '0;
                    i_d     = i_q + ONE_IDX;
                    state_d = S_ISSUE;
                end else begin
                    j_d     = j_q + ONE_IDX;
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered
        mul_req_d = (state_d == S_ISSUE);
        busy_d    = (state_d == S_ISSUE) || (state_d == S_ACCUM);
        done_d    = (state_d == S_DONE);
        mul_a_d   = get_word(a_d, i_d);
        mul_b_d   = get_word(b_d, j_d);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            w_q         <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            a_q         <= a_d;
            b_q         <= b_d;
            w_q         <= w_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_req_q   <= mul_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mul_req   = mul_req_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign W         = w_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign proto_err = proto_err_q;

endmodule
